// File: rtl/cp0_irq_ctrl_if.sv
// M-stage pipeline <-> CP0 bundle: mtc0/mfc0 access, exception inputs, interrupt lines, redirect outputs.
// Master is the pipeline side, slave is the CP0 controller.
interface cp0_irq_ctrl_if #(
  parameter int NUM_HWINT = 6
);
  logic                 we;
  logic [4:0]           cp0_addr;
  logic [31:0]          cp0_in;
  logic [31:0]          cp0_out;
  logic [31:0]          vpc;
  logic                 bd_in;
  logic [4:0]           exc_code_in;
  logic [NUM_HWINT-1:0] hw_int;
  logic                 exl_clr;
  logic [31:0]          epc_out;
  logic                 req;
  logic [NUM_HWINT-1:0] int_ack;

  modport master (
    output we, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    input  cp0_out, epc_out, req, int_ack
  );

  modport slave (
    input  we, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, hw_int, exl_clr,
    output cp0_out, epc_out, req, int_ack
  );
endinterface

// File: rtl/cp0_irq_ctrl.sv
// CP0 exception/interrupt controller at the M stage: merges hw lines, Count/Compare timer and exception code.
// req/cp0_out/epc_out are combinational, state and int_ack update on the next clk edge; no backpressure.
module cp0_irq_ctrl #(
  parameter int          NUM_HWINT = 6,
  parameter bit          TIMER_EN  = 1'b1,
  parameter int          COUNT_DIV = 1,
  parameter logic [31:0] PRID      = 32'h0000_4B37
) (
  input logic           clk,
  input logic           reset,
  cp0_irq_ctrl_if.slave bus
);

  localparam int            PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_SR      = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;
  localparam logic [4:0] A_PRID    = 5'd15;

  logic [5:0]           im;
  logic                 exl;
  logic                 ie;
  logic                 bd;
  logic [5:0]           ip_hw;
  logic                 ip_tmr;
  logic [4:0]           exc_code;
  logic [31:0]          epc;
  logic [31:0]          count;
  logic [31:0]          compare;
  logic [PW-1:0]        presc;
  logic                 timer_pend;
  logic [NUM_HWINT-1:0] int_ack_q;

  logic [5:0]  hw_ext;
  logic [5:0]  ip;
  logic [5:0]  pend_hw;
  logic [5:0]  ack_sel;
  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        wr;
  logic        tick;
  logic [31:0] epc_wdata;
  logic [31:0] cp0_rd;

  // Timer and hw line 5 share IP15; ack selection only looks at the hw-origin bits.
  assign hw_ext    = 6'(bus.hw_int);
  assign ip        = {ip_hw[5] | ip_tmr, ip_hw[4:0]};
  assign pend_hw   = ip_hw & im;
  assign ack_sel   = pend_hw & (~pend_hw + 6'd1);

  assign int_req   = ie & ~exl & (|(ip & im));
  assign exc_req   = ~exl & (bus.exc_code_in != 5'd0);
  assign req       = int_req | exc_req;
  assign wr        = bus.we & ~req;
  assign tick      = (presc == PRESC_LAST);
  assign epc_wdata = {bus.cp0_in[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd         <= 1'b0;
      ip_hw      <= '0;
      ip_tmr     <= 1'b0;
      exc_code   <= '0;
      epc        <= '0;
      count      <= '0;
      compare    <= '0;
      presc      <= '0;
      timer_pend <= 1'b0;
      int_ack_q  <= '0;
    end else begin
      ip_hw     <= hw_ext;
      ip_tmr    <= TIMER_EN & timer_pend;
      int_ack_q <= '0;

      if (req) begin
        exl      <= 1'b1;
        bd       <= bus.bd_in;
        exc_code <= int_req ? 5'd0 : bus.exc_code_in;
        epc      <= bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
        if (int_req) begin
          int_ack_q <= ack_sel[NUM_HWINT-1:0];
        end
      end else begin
        if (wr && bus.cp0_addr == A_SR) begin
          im  <= bus.cp0_in[15:10];
          exl <= bus.cp0_in[1];
          ie  <= bus.cp0_in[0];
        end
        // eret overrides a same-cycle SR write for the EXL bit.
        if (bus.exl_clr) begin
          exl <= 1'b0;
        end
        if (wr && bus.cp0_addr == A_EPC) begin
          epc <= epc_wdata;
        end
      end

      if (TIMER_EN) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          count <= count + 32'd1;
          if (count == compare) begin
            timer_pend <= 1'b1;
          end
        end
        if (wr && bus.cp0_addr == A_COUNT) begin
          count <= bus.cp0_in;
          presc <= '0;
        end
        // Compare write acknowledges the timer and beats a same-cycle match.
        if (wr && bus.cp0_addr == A_COMPARE) begin
          compare    <= bus.cp0_in;
          timer_pend <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    cp0_rd = '0;
    case (bus.cp0_addr)
      A_COUNT:   cp0_rd = TIMER_EN ? count : 32'd0;
      A_COMPARE: cp0_rd = TIMER_EN ? compare : 32'd0;
      A_SR:      cp0_rd = {16'd0, im, 8'd0, exl, ie};
      A_CAUSE:   cp0_rd = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
      A_EPC:     cp0_rd = epc;
      A_PRID:    cp0_rd = PRID;
      default:   cp0_rd = '0;
    endcase
  end

  assign bus.cp0_out = cp0_rd;
  assign bus.req     = req;
  assign bus.int_ack = int_ack_q;
  assign bus.epc_out = (wr && bus.cp0_addr == A_EPC) ? epc_wdata : epc;

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Directed bench for cp0_irq_ctrl: a register-level model is checked against the DUT every negedge,
// plus literal expectations at the key points of each scenario.
module tb_cp0_irq_ctrl;

  localparam int          N    = 6;
  localparam int          DIV  = 2;
  localparam logic [31:0] PRID = 32'h0000_4B37;

  logic clk = 1'b0;
  logic reset;
  logic chk_en;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cp0_irq_ctrl_if #(.NUM_HWINT(N)) bus ();

  cp0_irq_ctrl #(
    .NUM_HWINT (N),
    .TIMER_EN  (1'b1),
    .COUNT_DIV (DIV),
    .PRID      (PRID)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model state, named after the architectural fields.
  logic        m_ie, m_exl, m_bd, m_iptmr, m_pend;
  logic [5:0]  m_im, m_iphw, m_ack;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_count, m_cmp;
  int          m_div;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_int_req();
    logic [5:0] ipf;
    ipf = m_iphw | {m_iptmr, 5'd0};
    return m_ie && !m_exl && ((ipf & m_im) != 6'd0);
  endfunction

  function automatic logic m_req();
    return m_int_req() || (!m_exl && bus.exc_code_in != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] ipv;
    ipv = 32'(m_iphw | {m_iptmr, 5'd0});
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_cmp;
      5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (ipv << 10) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model_p
    logic        r, ir, wr_ok, found, n_pend;
    logic [5:0]  ack;
    logic [31:0] n_count;
    int          n_div;
    if (reset) begin
      m_ie <= 0; m_exl <= 0; m_bd <= 0; m_iptmr <= 0; m_pend <= 0;
      m_im <= 0; m_iphw <= 0; m_ack <= 0; m_code <= 0;
      m_epc <= 0; m_count <= 0; m_cmp <= 0; m_div <= 0;
    end else begin
      r     = m_req();
      ir    = m_int_req();
      wr_ok = bus.we && !r;
      ack   = '0;
      found = 1'b0;
      if (ir) begin
        for (int i = 0; i < N; i++) begin
          if (!found && m_iphw[i] && m_im[i]) begin
            ack[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
      m_ack   <= ack;
      m_iphw  <= bus.hw_int;
      m_iptmr <= m_pend;
      if (r) begin
        m_exl  <= 1'b1;
        m_bd   <= bus.bd_in;
        m_code <= ir ? 5'd0 : bus.exc_code_in;
        m_epc  <= bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
      end else begin
        if (wr_ok && bus.cp0_addr == 5'd12) begin
          m_im  <= bus.cp0_in[15:10];
          m_exl <= bus.cp0_in[1];
          m_ie  <= bus.cp0_in[0];
        end
        if (bus.exl_clr) m_exl <= 1'b0;
        if (wr_ok && bus.cp0_addr == 5'd14) m_epc <= bus.cp0_in & ~32'h3;
      end
      n_pend  = m_pend;
      n_count = m_count;
      n_div   = m_div + 1;
      if (n_div == DIV) begin
        n_div   = 0;
        n_count = m_count + 32'd1;
        if (m_count == m_cmp) n_pend = 1'b1;
      end
      if (wr_ok && bus.cp0_addr == 5'd9) begin
        n_count = bus.cp0_in;
        n_div   = 0;
      end
      if (wr_ok && bus.cp0_addr == 5'd11) begin
        m_cmp <= bus.cp0_in;
        n_pend = 1'b0;
      end
      m_pend  <= n_pend;
      m_count <= n_count;
      m_div   <= n_div;
    end
  end

  always @(negedge clk) begin : cmp_p
    logic [31:0] e_epc;
    if (chk_en) begin
      e_epc = (bus.we && !m_req() && bus.cp0_addr == 5'd14) ? (bus.cp0_in & ~32'h3) : m_epc;
      chk("model_req", 32'(bus.req), 32'(m_req()));
      chk("model_cp0_out", bus.cp0_out, m_read(bus.cp0_addr));
      chk("model_epc_out", bus.epc_out, e_epc);
      chk("model_int_ack", 32'(bus.int_ack), 32'(m_ack));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.cp0_addr = a; bus.cp0_in = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] e, input string nm);
    bus.cp0_addr = a;
    #1;
    chk(nm, bus.cp0_out, e);
  endtask

  task automatic eret();
    bus.exl_clr = 1'b1;
    tick();
    bus.exl_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; chk_en = 1'b0;
    bus.we = 0; bus.cp0_addr = 0; bus.cp0_in = 0; bus.vpc = 0; bus.bd_in = 0;
    bus.exc_code_in = 0; bus.hw_int = 0; bus.exl_clr = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk_en = 1'b1;
    peek(5'd15, PRID, "rst_prid");
    peek(5'd12, 32'h0, "rst_sr");
    peek(5'd13, 32'h0, "rst_cause");
    chk("rst_req", 32'(bus.req), 32'h0);
    // park Compare far away so the timer stays quiet until its own scenario
    wr(5'd11, 32'hFFFF_0000);

    // exception capture
    wr(5'd12, 32'h1);
    bus.exc_code_in = 5'd10; bus.vpc = 32'h3010; bus.bd_in = 0;
    #1 chk("exc_req", 32'(bus.req), 32'h1);
    tick();
    bus.exc_code_in = 0;
    peek(5'd13, 32'h0000_0028, "exc_cause");
    peek(5'd14, 32'h0000_3010, "exc_epc");
    peek(5'd12, 32'h0000_0003, "exc_sr");
    tick();
    bus.exc_code_in = 5'd4;
    #1 chk("exc_under_exl", 32'(bus.req), 32'h0);
    tick();
    bus.exc_code_in = 0;
    eret();
    peek(5'd12, 32'h1, "eret_sr");

    // delay-slot interrupt
    wr(5'd12, 32'h0000_FC01);
    bus.hw_int = 6'b000100;
    tick();
    bus.bd_in = 1; bus.vpc = 32'h3024;
    #1 chk("dsi_req", 32'(bus.req), 32'h1);
    tick();
    bus.bd_in = 0;
    chk("dsi_ack", 32'(bus.int_ack), 32'h04);
    peek(5'd13, 32'h8000_1000, "dsi_cause");
    peek(5'd14, 32'h0000_3020, "dsi_epc");
    tick();
    chk("dsi_ack_one_cycle", 32'(bus.int_ack), 32'h0);
    bus.hw_int = 0;
    eret();

    // interrupt beats a same-cycle exception
    bus.hw_int = 6'b000001; bus.vpc = 32'h3030;
    tick();
    bus.exc_code_in = 5'd12;
    #1 chk("ivx_req", 32'(bus.req), 32'h1);
    tick();
    bus.exc_code_in = 0; bus.hw_int = 0;
    chk("ivx_ack", 32'(bus.int_ack), 32'h01);
    peek(5'd13, 32'h0000_0400, "ivx_cause");
    peek(5'd14, 32'h0000_3030, "ivx_epc");
    eret();

    // mtc0 EPC blocked by a same-cycle exception, then accepted with bypass
    bus.exc_code_in = 5'd8; bus.vpc = 32'h5000;
    bus.we = 1; bus.cp0_addr = 5'd14; bus.cp0_in = 32'h4000;
    #1 chk("blk_req", 32'(bus.req), 32'h1);
    chk("blk_epc_out", bus.epc_out, 32'h3030);
    tick();
    bus.exc_code_in = 0; bus.cp0_in = 32'h4003;
    #1 chk("byp_epc_out", bus.epc_out, 32'h4000);
    chk("blk_epc_reg", bus.cp0_out, 32'h5000);
    tick();
    bus.we = 0;
    peek(5'd14, 32'h4000, "mtc0_epc");
    eret();

    // masking, software EXL, eret vs SR write, eret vs req
    wr(5'd12, 32'h0000_0401);
    bus.hw_int = 6'b000010;
    tick();
    #1 chk("im_masked_req", 32'(bus.req), 32'h0);
    wr(5'd12, 32'h0000_FC03);
    #1 chk("exl_masks_req", 32'(bus.req), 32'h0);
    bus.exl_clr = 1; bus.we = 1; bus.cp0_addr = 5'd12; bus.cp0_in = 32'h0000_FC03;
    tick();
    bus.exl_clr = 0; bus.we = 0;
    peek(5'd12, 32'h0000_FC01, "eret_beats_sr");
    chk("eret_then_req", 32'(bus.req), 32'h1);
    tick();
    bus.hw_int = 0;
    chk("eret_int_ack", 32'(bus.int_ack), 32'h02);
    eret();
    bus.exc_code_in = 5'd3; bus.exl_clr = 1;
    #1 chk("req_with_eret", 32'(bus.req), 32'h1);
    tick();
    bus.exc_code_in = 0; bus.exl_clr = 0;
    peek(5'd12, 32'h0000_FC03, "req_beats_eret");
    eret();

    // timer, prescale by 2
    wr(5'd12, 32'h0000_8001);
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    repeat (12) tick();
    peek(5'd9, 32'd6, "tmr_count");
    chk("tmr_req_pre", 32'(bus.req), 32'h0);
    tick();
    bus.vpc = 32'h3100;
    #1 chk("tmr_req", 32'(bus.req), 32'h1);
    tick();
    chk("tmr_ack_zero", 32'(bus.int_ack), 32'h0);
    peek(5'd13, 32'h0000_8000, "tmr_cause");
    wr(5'd11, 32'h100);
    tick();
    peek(5'd13, 32'h0, "tmr_cleared");
    eret();
    wr(5'd9, 32'hFFFF_FFFF);
    peek(5'd9, 32'hFFFF_FFFF, "wrap_pre");
    tick();
    tick();
    peek(5'd9, 32'h0, "wrap_post");

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
